// File: rtl/bcd_pkg.sv
// Shared types and helpers for the digit-serial BCD adder/subtractor.
// BCD_SIGN_MAG_EN adds the FIX state that turns a borrowed result into a magnitude.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

`ifdef BCD_SIGN_MAG_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
`endif

  localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

  // Widest operand is_valid_bcd accepts; narrower operands are zero-extended.
  localparam int unsigned BCD_MAX_VEC_W = 256;

  function automatic bcd_digit_t nines_comp(input bcd_digit_t d);
    return BCD_MAX_DIGIT - d;
  endfunction

  function automatic logic is_valid_bcd(input logic [BCD_MAX_VEC_W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < int'(BCD_MAX_VEC_W / 4); i++) begin
      if (v[4*i +: 4] > BCD_MAX_DIGIT) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// Single BCD digit adder: a + b + cin with +6 decimal correction.
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       cin,
  output bcd_digit_t sum,
  output logic       cout
);

  logic [4:0] raw;

  always_comb begin
    raw  = 5'(a) + 5'(b) + 5'(cin);
    cout = (raw > 5'd9);
    sum  = cout ? 4'(raw + 5'd6) : raw[3:0];
  end

endmodule

// File: rtl/bcd_addsub_serial.sv
// Digit-serial packed-BCD adder/subtractor, LSD first, start/busy/done handshake.
// Define BCD_SIGN_MAG_EN to return |A-B| (extra FIX pass) instead of ten's complement on borrow.
module bcd_addsub_serial
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS           = 8,
  parameter int unsigned DIGITS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  sub,
  input  logic [4*DIGITS-1:0]   arg1,
  input  logic [4*DIGITS-1:0]   arg2,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   result,
  output logic                  carry,
  output logic                  invalid
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned SW = 4 * DIGITS_PER_CYCLE;
  localparam int unsigned N  = DIGITS / DIGITS_PER_CYCLE;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  if ((DIGITS % DIGITS_PER_CYCLE) != 0) begin : g_bad_dpc
    $error("DIGITS_PER_CYCLE must divide DIGITS");
  end
  if (W > BCD_MAX_VEC_W) begin : g_bad_digits
    $error("DIGITS exceeds the supported operand width");
  end

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [W-1:0]        a_q, a_d, b_q, b_d, res_q, res_d;
  logic [W-1:0]        res_shift, result_d;
  logic                cin_q, cin_d, sub_q, sub_d, inv_q, inv_d;
  logic                carry_d, invalid_d, busy_d, done_d;
  logic [SW-1:0]       sum_vec;
  logic [DIGITS_PER_CYCLE:0] chain;
  logic                last_c, start_inv_c;

  // Carry chain of digit adders; B path is nine's-complemented for subtraction.
  assign chain[0] = cin_q;
  for (genvar g = 0; g < int'(DIGITS_PER_CYCLE); g++) begin : g_chain
    bcd_digit_t b_dig;
    assign b_dig = sub_q ? nines_comp(b_q[4*g +: 4]) : b_q[4*g +: 4];
    bcd_digit_adder u_add (
      .a    (a_q[4*g +: 4]),
      .b    (b_dig),
      .cin  (chain[g]),
      .sum  (sum_vec[4*g +: 4]),
      .cout (chain[g+1])
    );
  end

  // New digits enter at the MSD side so the first digit ends up at bits [3:0].
  assign res_shift   = W'({sum_vec, res_q} >> SW);
  assign last_c      = (cnt_q == CW'(N - 1));
  assign start_inv_c = ~(is_valid_bcd(BCD_MAX_VEC_W'(arg1)) & is_valid_bcd(BCD_MAX_VEC_W'(arg2)));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cin_q   <= 1'b0;
      sub_q   <= 1'b0;
      inv_q   <= 1'b0;
      result  <= '0;
      carry   <= 1'b0;
      invalid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cin_q   <= cin_d;
      sub_q   <= sub_d;
      inv_q   <= inv_d;
      result  <= result_d;
      carry   <= carry_d;
      invalid <= invalid_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    cin_d     = cin_q;
    sub_d     = sub_q;
    inv_d     = inv_q;
    result_d  = result;
    carry_d   = carry;
    invalid_d = invalid;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d   = RUN;
          cnt_d     = '0;
          a_d       = arg1;
          b_d       = arg2;
          res_d     = '0;
          sub_d     = sub;
          cin_d     = sub;
          inv_d     = start_inv_c;
          result_d  = '0;
          carry_d   = 1'b0;
          invalid_d = 1'b0;
          busy_d    = 1'b1;
        end
      end

      RUN: begin
        a_d    = a_q >> SW;
        b_d    = b_q >> SW;
        res_d  = res_shift;
        cin_d  = chain[DIGITS_PER_CYCLE];
        cnt_d  = cnt_q + CW'(1);
        busy_d = 1'b1;
        if (last_c) begin
`ifdef BCD_SIGN_MAG_EN
          // Borrow: second pass computes 0 - raw result to recover the magnitude.
          if (sub_q && !chain[DIGITS_PER_CYCLE] && !inv_q) begin
            state_d = FIX;
            cnt_d   = '0;
            a_d     = '0;
            b_d     = res_shift;
            cin_d   = 1'b1;
            sub_d   = 1'b1;
          end else
`endif
          begin
            state_d   = DONE;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            result_d  = inv_q ? '0 : res_shift;
            carry_d   = ~inv_q & (sub_q ^ chain[DIGITS_PER_CYCLE]);
            invalid_d = inv_q;
          end
        end
      end

`ifdef BCD_SIGN_MAG_EN
      FIX: begin
        a_d    = a_q >> SW;
        b_d    = b_q >> SW;
        res_d  = res_shift;
        cin_d  = chain[DIGITS_PER_CYCLE];
        cnt_d  = cnt_q + CW'(1);
        busy_d = 1'b1;
        if (last_c) begin
          state_d   = DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          result_d  = res_shift;
          carry_d   = 1'b1;
          invalid_d = 1'b0;
        end
      end
`endif

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Scoreboard bench for bcd_addsub_serial: a 1-digit/cycle and a 4-digit/cycle instance.
// done is registered on the N-th edge after the accepting edge (N+1 edges counting the start edge).
module tb_bcd_addsub_serial;

  localparam int N1 = 8;
  localparam int N4 = 2;
  localparam longint LIM = 64'd100000000;

  typedef struct {
    logic [31:0] res;
    logic        c;
    logic        inv;
    int          done_cyc;
    int          busy_cyc;
  } exp_t;

  logic        clk;
  logic        resetn;
  logic        start1, sub1, busy1, done1, carry1, invalid1;
  logic [31:0] a1, b1, result1;
  logic        start4, sub4, busy4, done4, carry4, invalid4;
  logic [31:0] a4, b4, result4;

  exp_t q1[$];
  exp_t q4[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   bcnt1 = 0;
  int   bcnt4 = 0;
  int   acc;

  bcd_addsub_serial #(.DIGITS(8), .DIGITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .resetn(resetn), .start(start1), .sub(sub1), .arg1(a1), .arg2(b1),
    .busy(busy1), .done(done1), .result(result1), .carry(carry1), .invalid(invalid1)
  );

  bcd_addsub_serial #(.DIGITS(8), .DIGITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .resetn(resetn), .start(start4), .sub(sub4), .arg1(a4), .arg2(b4),
    .busy(busy4), .done(done4), .result(result4), .carry(carry4), .invalid(invalid4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic longint bcd2int(input logic [31:0] v);
    longint r;
    r = 0;
    for (int i = 7; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [31:0] int2bcd(input longint x);
    logic [31:0] v;
    longint r;
    r = x;
    for (int i = 0; i < 8; i++) begin
      v[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return v;
  endfunction

  // Reference: integer arithmetic on the decoded operands.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                 input int n, input int accept_cyc);
    exp_t   e;
    longint ai, bi, r;
    logic   inv;
    int     lat;
    inv = 1'b0;
    lat = n;
    e.c = 1'b0;
    for (int i = 0; i < 8; i++)
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) inv = 1'b1;
    ai = bcd2int(a);
    bi = bcd2int(b);
    if (inv) begin
      r = 0;
    end else if (!s) begin
      r   = ai + bi;
      e.c = (r >= LIM);
      r   = r % LIM;
    end else if (ai >= bi) begin
      r = ai - bi;
    end else begin
      e.c = 1'b1;
`ifdef BCD_SIGN_MAG_EN
      r   = bi - ai;
      lat = 2 * n;
`else
      r   = LIM - (bi - ai);
`endif
    end
    e.res      = int2bcd(r);
    e.inv      = inv;
    e.done_cyc = accept_cyc + lat;
    e.busy_cyc = lat;
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    assert (got === expv) else begin
      failures++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, expv);
    end
  endtask

  task automatic sb_check(input string tag, input exp_t e, input logic [31:0] r, input logic c,
                          input logic inv, input logic bsy, input int bc);
    check({tag, "_result"}, 64'(r), 64'(e.res));
    check({tag, "_carry"}, 64'(c), 64'(e.c));
    check({tag, "_invalid"}, 64'(inv), 64'(e.inv));
    check({tag, "_done_cycle"}, 64'(cyc), 64'(e.done_cyc));
    check({tag, "_busy_cycles"}, 64'(bc), 64'(e.busy_cyc));
    check({tag, "_busy_at_done"}, 64'(bsy), 64'(0));
  endtask

  always @(negedge clk) begin
    if (!resetn) begin
      bcnt1 = 0;
    end else begin
      if (busy1) bcnt1++;
      if (done1) begin
        if (q1.size() == 0) check("dut1_spurious_done", 64'(done1), 64'(0));
        else sb_check("dut1", q1.pop_front(), result1, carry1, invalid1, busy1, bcnt1);
        bcnt1 = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!resetn) begin
      bcnt4 = 0;
    end else begin
      if (busy4) bcnt4++;
      if (done4) begin
        if (q4.size() == 0) check("dut4_spurious_done", 64'(done4), 64'(0));
        else sb_check("dut4", q4.pop_front(), result4, carry4, invalid4, busy4, bcnt4);
        bcnt4 = 0;
      end
    end
  end

  task automatic op1(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    a1 = a; b1 = b; sub1 = s; start1 = 1'b1;
    @(posedge clk);
    #1;
    q1.push_back(model(a, b, s, N1, cyc));
    @(negedge clk);
    start1 = 1'b0; a1 = $urandom; b1 = $urandom; sub1 = 1'($urandom);
  endtask

  task automatic op4(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    a4 = a; b4 = b; sub4 = s; start4 = 1'b1;
    @(posedge clk);
    #1;
    q4.push_back(model(a, b, s, N4, cyc));
    @(negedge clk);
    start4 = 1'b0; a4 = $urandom; b4 = $urandom; sub4 = 1'($urandom);
  endtask

  task automatic drain1();
    for (int i = 0; i < 100 && q1.size() != 0; i++) @(negedge clk);
    check("dut1_drain", 64'(q1.size()), 64'(0));
  endtask

  task automatic drain4();
    for (int i = 0; i < 100 && q4.size() != 0; i++) @(negedge clk);
    check("dut4_drain", 64'(q4.size()), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    start1 = 1'b0; sub1 = 1'b0; a1 = '0; b1 = '0;
    start4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0;
    #12;
    check("reset_result", 64'(result1), 64'(0));
    check("reset_carry", 64'(carry1), 64'(0));
    check("reset_invalid", 64'(invalid1), 64'(0));
    check("reset_busy", 64'(busy1), 64'(0));
    check("reset_done", 64'(done1), 64'(0));
    @(negedge clk);
    resetn = 1'b1;

    // Directed arithmetic, including wrap and borrow boundaries.
    op1(32'h12345678, 32'h87654321, 1'b0); drain1();
    op1(32'h99999999, 32'h00000001, 1'b0); drain1();
    op1(32'h00000005, 32'h00000007, 1'b1); drain1();
    op1(32'h00000000, 32'h00000000, 1'b1); drain1();
    op1(32'h00001000, 32'h00000001, 1'b1); drain1();
    op1(32'h87654321, 32'h12345678, 1'b1); drain1();
    repeat (4) @(negedge clk);
    check("result_hold", 64'(result1), 64'(32'h75308643));

    // Invalid nibble, then a valid start clears the flag on its edge.
    op1(32'h0000000A, 32'h00000001, 1'b0); drain1();
    repeat (3) @(negedge clk);
    check("invalid_hold", 64'(invalid1), 64'(1));
    op1(32'h40000000, 32'h60000000, 1'b0);
    check("invalid_cleared_on_start", 64'(invalid1), 64'(0));
    drain1();

    // Start pulsed mid-RUN with other operands is ignored.
    op1(32'h11111111, 32'h22222222, 1'b0);
    repeat (2) @(negedge clk);
    check("busy_mid_run", 64'(busy1), 64'(1));
    a1 = 32'h99999999; b1 = 32'h99999999; sub1 = 1'b1; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    drain1();

    // Start held high re-triggers in the DONE cycle: done pulses N+1 apart.
    @(negedge clk);
    a1 = 32'h50000000; b1 = 32'h50000000; sub1 = 1'b0; start1 = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    q1.push_back(model(32'h50000000, 32'h50000000, 1'b0, N1, acc));
    q1.push_back(model(32'h50000000, 32'h50000000, 1'b0, N1, acc + N1 + 1));
    repeat (N1 + 1) @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    drain1();

    // Reset in the 4th RUN cycle aborts without a done pulse.
    op1(32'h23456789, 32'h98765432, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    check("busy_before_reset", 64'(busy1), 64'(1));
    void'(q1.pop_back());
    resetn = 1'b0;
    #1;
    check("abort_busy", 64'(busy1), 64'(0));
    check("abort_done", 64'(done1), 64'(0));
    check("abort_result", 64'(result1), 64'(0));
    check("abort_carry", 64'(carry1), 64'(0));
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    op1(32'h23456789, 32'h98765432, 1'b1); drain1();

    // Four digits per cycle.
    op4(32'h00001000, 32'h00000001, 1'b1); drain4();
    op4(32'h12345678, 32'h87654321, 1'b0); drain4();
    op4(32'h00000005, 32'h00000007, 1'b1); drain4();
    op4(32'h0000A000, 32'h00000001, 1'b1); drain4();
    op4(32'h99999999, 32'h00000001, 1'b0); drain4();

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_addsub_serial.md
Name: bcd_addsub_serial

Overview:
Parametrised digit-serial BCD adder/subtractor, the next generation of the team's serial BCD adder.
- Processes DIGITS_PER_CYCLE packed-BCD digits per clock, LSD first.
- Supports add or ten's-complement subtract, selected per operation.
- Uses a start/busy/done handshake, reports carry/borrow, and detects non-BCD input nibbles.
- Sits behind the APB register front end as its arithmetic engine.

Parameters:
DIGITS, 8, number of BCD digits per operand; operand width = 4*DIGITS.
DIGITS_PER_CYCLE, 1, digits processed per RUN cycle; must divide DIGITS; elaboration error otherwise.

Ports:
clk  input  1  clock, rising edge.
resetn  input  1  asynchronous, active-low reset.
start  input  1  request new operation; sampled only when not busy.
sub  input  1  0 = arg1+arg2, 1 = arg1-arg2; sampled with start.
arg1  input  4*DIGITS  packed-BCD operand A.
arg2  input  4*DIGITS  packed-BCD operand B.
busy  output  1  operation in progress.
done  output  1  one-cycle pulse; result and flags valid from this cycle.
result  output  4*DIGITS  packed-BCD result.
carry  output  1  add: decimal carry out of MSD (overflow); sub: borrow, i.e. A<B.
invalid  output  1  some nibble of arg1/arg2 was >9 at start.

Behaviour:
- Reset: asynchronous. All outputs go to 0 and the FSM goes to IDLE. Reset mid-operation aborts with no done pulse.
- FSM states: IDLE, RUN, (FIX when BCD_SIGN_MAG_EN), DONE.
- Let N = DIGITS/DIGITS_PER_CYCLE.
- start is accepted in IDLE or DONE:
  - On that edge, latch arg1, arg2 and sub, compute invalid, and clear the digit counter.
  - Carry-in is sub. The B path uses the nine's complement (9-d) when sub=1.
  - Go to RUN. busy=1 from the next cycle.
- RUN:
  - Each cycle, chain DIGITS_PER_CYCLE digit adders.
  - Shift the produced digits into the result shift register, MSD side, so the LSD ends at bits [3:0].
  - Register the chain carry-out as the next carry-in.
  - After N RUN cycles, go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. done rises N+1 edges after the start edge (without fix-up).
- Flags:
  - Add: carry = final carry-out.
  - Sub: carry = NOT final carry-out (borrow). The raw result is the ten's complement of |A-B| when borrow=1.
- invalid=1: result forced to 0 and carry=0, with the same latency. The computation is not short-circuited.
- result, carry and invalid hold from DONE until the next accepted start. On that start edge they are cleared to 0.
- start while busy is ignored with no queueing. start held high re-triggers in the DONE cycle (back-to-back).
- sub, arg1 and arg2 are don't-care outside the accepting edge.
- Wrap: 99..9+1 gives result 0, carry=1. 0-0 gives result 0, carry=0.

Optional Feature:
BCD_SIGN_MAG_EN
- Defined: on borrow, FSM goes RUN->FIX. FIX runs N further cycles computing 0 - result (ten's complement) through the same adders, so the result becomes magnitude |A-B| and carry stays 1. done is delayed by N cycles. No FIX when borrow=0 or invalid=1.
- Undefined: no FIX state; raw ten's-complement result with carry=1.

Decomposition:
- Package bcd_pkg:
  - typedef bcd_digit_t (logic [3:0]).
  - FSM state enum.
  - Constant BCD_MAX_DIGIT = 9.
  - Function nines_comp(digit).
  - Function is_valid_bcd(vector).
- Sub-module bcd_digit_adder:
  - Combinational single-digit a+b+cin with +6 correction; outputs sum and cout.
  - Instantiated DIGITS_PER_CYCLE times in a carry chain.

Test Plan:
1. DIGITS=8, DPC=1: add 12345678+87654321 -> result 99999999, carry 0, done exactly 9 edges after start edge, busy high 8 cycles.
2. Add 99999999+00000001 -> result 00000000, carry 1; then sub 00000005-00000007 -> 99999998, carry 1 (macro off); 00000002, carry 1, done delayed +8 (macro on).
3. DPC=4: sub 00001000-00000001 -> 00000999, carry 0, done 3 edges after start; DPC=3 elaboration fails.
4. arg1=0000000A, arg2=1 -> invalid 1, result 0, carry 0, normal latency; next valid start clears invalid.
5. Second start pulsed mid-RUN with different args -> ignored, first result unchanged; start held high -> new op accepted in DONE cycle, back-to-back done pulses 9 cycles apart.
6. resetn low in 4th RUN cycle -> outputs 0 immediately, no done; operation after release completes correctly.
